// File: rtl/button_conditioner.sv
// Four-channel push-button conditioner: synchronise, debounce, edge pulses,
// long-press hold and a two-button combo pulse.
// "release" is a reserved word, so the release pulse port is named release_.

// One button channel: 2-flop synchroniser, debounce FSM, hold counter.
module button_channel #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int HOLD_CYCLES     = 50000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic p,          // raw button, active-low
    output logic level,      // debounced, active-high
    output logic press,
    output logic release_,
    output logic hold
);
    localparam int CW = 27;
    localparam logic [CW-1:0] DB_LAST   = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } state_t;

    state_t          state, state_n;
    logic [CW-1:0]   cnt, cnt_n;
    logic [CW-1:0]   hcnt, hcnt_n;
    logic [1:0]      sync;
    logic            pin;
    logic            level_n, press_n, release_n, hold_n;

    assign pin = sync[1];

    // Two-flop synchroniser; idles high so reset looks like "not pressed".
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync <= 2'b11;
        else        sync <= {sync[0], p};
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            hcnt     <= '0;
            level    <= 1'b0;
            press    <= 1'b0;
            release_ <= 1'b0;
            hold     <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            hcnt     <= hcnt_n;
            level    <= level_n;
            press    <= press_n;
            release_ <= release_n;
            hold     <= hold_n;
        end
    end

    // Next-state and stability counter: a level change is accepted only after
    // DEBOUNCE_CYCLES consecutive samples of the new value.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        case (state)
            IDLE: begin
                if (!pin) begin
                    state_n = PRESS_WAIT;
                    cnt_n   = '0;
                end
            end
            PRESS_WAIT: begin
                if (pin)                 state_n = IDLE;
                else if (cnt == DB_LAST) state_n = PRESSED;
                else                     cnt_n   = cnt + CW'(1);
            end
            PRESSED: begin
                if (pin) begin
                    state_n = RELEASE_WAIT;
                    cnt_n   = '0;
                end
            end
            RELEASE_WAIT: begin
                if (!pin)                state_n = PRESSED;
                else if (cnt == DB_LAST) state_n = IDLE;
                else                     cnt_n   = cnt + CW'(1);
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase
    end

    // Output decode from the transition; a bounce back from RELEASE_WAIT keeps
    // level high, so the hold counter and hold survive it untouched.
    always_comb begin
        level_n   = (state_n == PRESSED) || (state_n == RELEASE_WAIT);
        press_n   = (state == PRESS_WAIT)   && (state_n == PRESSED);
        release_n = (state == RELEASE_WAIT) && (state_n == IDLE);
        hcnt_n    = hcnt;
        if (press_n)
            hcnt_n = '0;
        else if (level && hcnt != HOLD_LAST)
            hcnt_n = hcnt + CW'(1);
        // Registered off the current count, so hold rises HOLD_CYCLES after
        // level and falls with the release pulse.
        hold_n = level_n && level && (hcnt == HOLD_LAST);
    end
endmodule

// Top: four identical independent channels plus the combo detector.
module button_conditioner #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int HOLD_CYCLES     = 50000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] P,
    output logic [3:0] level,
    output logic [3:0] press,
    output logic [3:0] release_,
    output logic [3:0] hold,
    output logic       combo
);
    localparam int NUM_LANES = 4;

    logic both_q;

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_ch
        button_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .HOLD_CYCLES     (HOLD_CYCLES)
        ) u_ch (
            .clk      (clk),
            .rst_n    (rst_n),
            .p        (P[i]),
            .level    (level[i]),
            .press    (press[i]),
            .release_ (release_[i]),
            .hold     (hold[i])
        );
    end

    // Combo fires once on the rising edge of level[0] & level[3].
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            both_q <= 1'b0;
            combo  <= 1'b0;
        end else begin
            both_q <= level[0] & level[3];
            combo  <= level[0] & level[3] & ~both_q;
        end
    end
endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with DEBOUNCE_CYCLES=4, HOLD_CYCLES=10.
// Inputs change and outputs are sampled 1 time unit after a rising edge.
module tb_button_conditioner;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] P = 4'hF;
    logic [3:0] level, press, release_, hold;
    logic       combo;

    int n_tests = 0;
    int n_fail  = 0;

    button_conditioner #(.DEBOUNCE_CYCLES(4), .HOLD_CYCLES(10)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .P        (P),
        .level    (level),
        .press    (press),
        .release_ (release_),
        .hold     (hold),
        .combo    (combo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".level"}, 32'(level), 0);
        chk({tag, ".press"}, 32'(press), 0);
        chk({tag, ".rel"},   32'(release_), 0);
        chk({tag, ".hold"},  32'(hold), 0);
        chk({tag, ".combo"}, 32'(combo), 0);
    endtask

    initial begin
        // reset state
        #2;
        chk_all_zero("rst");
        step(2);
        rst_n = 1'b1;
        step(3);
        chk_all_zero("idle");

        // single press on bit 0: level/press at E+6, pulse gone at E+7
        P = 4'b1110;
        step(6);
        chk("p0.E5.level", 32'(level), 0);
        chk("p0.E5.press", 32'(press), 0);
        step(1);
        chk("p0.E6.level", 32'(level), 32'h1);
        chk("p0.E6.press", 32'(press), 32'h1);
        step(1);
        chk("p0.E7.press", 32'(press), 0);
        chk("p0.E7.level", 32'(level), 32'h1);
        // release: symmetric latency
        P = 4'b1111;
        step(6);
        chk("r0.E5.rel",   32'(release_), 0);
        chk("r0.E5.level", 32'(level), 32'h1);
        step(1);
        chk("r0.E6.rel",   32'(release_), 32'h1);
        chk("r0.E6.level", 32'(level), 0);
        step(1);
        chk("r0.E7.rel",   32'(release_), 0);

        // glitches on bit 1 shorter than the debounce window
        for (int k = 0; k < 5; k++) begin
            P = 4'b1101;
            for (int c = 0; c < 3; c++) begin
                step(1);
                chk("gl.lvpr", {level[1], press[1], release_[1]}, 0);
            end
            P = 4'b1111;
            for (int c = 0; c < 3; c++) begin
                step(1);
                chk("gl.lvpr", {level[1], press[1], release_[1]}, 0);
            end
        end
        step(4);
        chk("gl.end.level", 32'(level), 0);

        // hold on bit 2: hold rises 10 cycles after level
        P = 4'b1011;
        step(7);
        chk("h2.level", 32'(level), 32'h4);
        step(9);
        chk("h2.L9.hold", 32'(hold), 0);
        step(1);
        chk("h2.L10.hold", 32'(hold), 32'h4);
        step(10);
        chk("h2.L20.hold", 32'(hold), 32'h4);
        // 2-cycle bounce high: RELEASE_WAIT and back, hold/level stay
        P = 4'b1111;
        step(2);
        P = 4'b1011;
        for (int c = 0; c < 8; c++) begin
            step(1);
            chk("h2.bnc", {hold[2], level[2], release_[2]}, 3'b110);
        end
        // real release: release pulse and hold drop together
        P = 4'b1111;
        step(6);
        chk("h2.R5", {hold[2], release_[2]}, 2'b10);
        step(1);
        chk("h2.R6", {hold[2], release_[2], level[2]}, 3'b010);
        step(2);

        // combo: bit 0 at E, bit 3 at E+2
        P = 4'b1110;
        step(2);
        P = 4'b0110;
        step(5);
        chk("cb.E6", {level, 3'b0, combo}, {4'b0001, 4'b0000});
        step(1);
        chk("cb.E7.combo", 32'(combo), 0);
        step(1);
        chk("cb.E8", {level, 3'b0, combo}, {4'b1001, 4'b0000});
        step(1);
        chk("cb.E9.combo", 32'(combo), 1);
        step(1);
        chk("cb.E10.combo", 32'(combo), 0);
        P = 4'b1111;
        step(10);
        chk("cb.rel.level", 32'(level), 0);
        chk("cb.rel.combo", 32'(combo), 0);

        // simultaneous presses and releases on bits 1 and 2
        P = 4'b1001;
        step(7);
        chk("sim.press", 32'(press), 32'h6);
        P = 4'b1111;
        step(7);
        chk("sim.rel", 32'(release_), 32'h6);
        step(2);

        // reset mid-press on bit 1
        P = 4'b1101;
        step(7);
        chk("rp.level", 32'(level), 32'h2);
        rst_n = 1'b0;
        #1;
        chk_all_zero("rp.in");
        step(2);
        chk_all_zero("rp.hold");
        rst_n = 1'b1;
        step(6);
        chk("rp.E5.press", 32'(press), 0);
        chk("rp.E5.level", 32'(level), 0);
        step(1);
        chk("rp.E6.press", 32'(press), 32'h2);
        chk("rp.E6.level", 32'(level), 32'h2);
        step(1);
        chk("rp.E7.press", 32'(press), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
